// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw inputs and tick strobe in, clean levels and pulses out.
// The master side is the conditioner itself; the slave side is whoever drives the
// raw pins and consumes the conditioned outputs.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 4
);
    logic             tick_en;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        input  tick_en,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );

    modport slave (
        output tick_en,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel button conditioning: 2-flop synchronizer, tick-gated debounce,
// press/release edge pulses and hold-to-auto-repeat. All outputs are registered
// and every channel has its own counters.
module button_conditioner #(
    parameter int unsigned N_BTN      = 4,
    parameter int unsigned DB_CYCLES  = 255,
    parameter int unsigned RPT_DELAY  = 1024,
    parameter int unsigned RPT_PERIOD = 256
) (
    input logic                 clk,
    input logic                 rst,
    button_conditioner_if.master bus
);
    localparam int unsigned DW      = $clog2(DB_CYCLES + 1);
    localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam bit          RPT_EN  = (RPT_DELAY != 0);

    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    // With auto-repeat disabled the FSM never leaves idle, so this value is unused.
    localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_EN ? RPT_DELAY - 1 : 0);
    localparam logic [RW-1:0] PER_LAST   = RW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rpt_state_e;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] repeat_q, repeat_d;
    logic [N_BTN-1:0] rise, fall;

    logic [DW-1:0] db_cnt_q  [N_BTN];
    logic [DW-1:0] db_cnt_d  [N_BTN];
    logic [RW-1:0] rpt_cnt_q [N_BTN];
    logic [RW-1:0] rpt_cnt_d [N_BTN];
    rpt_state_e    state_q   [N_BTN];
    rpt_state_e    state_d   [N_BTN];

    // Synchronize raw inputs into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive mismatching ticks; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        rise    = '0;
        fall    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (bus.tick_en) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i]  = ~level_q[i];
                    db_cnt_d[i] = '0;
                    rise[i]     = ~level_q[i];
                    fall[i]     = level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
        press_d   = rise;
        release_d = fall;
    end

    // Auto-repeat next state: initial delay, then periodic pulses until release.
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            if (fall[i]) begin
                // Release wins over a coincident terminal count.
                state_d[i]   = StIdle;
                rpt_cnt_d[i] = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (rise[i] && RPT_EN) begin
                            state_d[i]   = StDelay;
                            rpt_cnt_d[i] = '0;
                        end
                    end
                    StDelay: begin
                        if (bus.tick_en) begin
                            if (rpt_cnt_q[i] == DELAY_LAST) begin
                                repeat_d[i]  = 1'b1;
                                rpt_cnt_d[i] = '0;
                                state_d[i]   = StRepeat;
                            end else begin
                                rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                            end
                        end
                    end
                    StRepeat: begin
                        if (bus.tick_en) begin
                            if (rpt_cnt_q[i] == PER_LAST) begin
                                repeat_d[i]  = 1'b1;
                                rpt_cnt_d[i] = '0;
                            end else begin
                                rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i]   = StIdle;
                        rpt_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Register debounce, repeat FSM and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]  <= '0;
                rpt_cnt_q[i] <= '0;
                state_q[i]   <= StIdle;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
                state_q[i]   <= state_d[i];
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_repeat  = repeat_q;
endmodule
